// File: rtl/object_ctrl_pkg.sv
// Shared definitions for the object display controllers: mode encoding,
// default frame geometry and the renderer output pair for each mode.
package object_ctrl_pkg;

  // Display mode of the rectangle object.
  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_RECT    = 2'd1,
    MODE_OVERLAY = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_t;

  // Default last counter values of a 640x480 VGA frame (800 x 525 total).
  localparam int DEFAULT_H_LAST = 799;
  localparam int DEFAULT_V_LAST = 524;

  // Renderer controls for a mode, packed as {full_screen, rectangle_select}.
  // BLINK drives rectangle_select from the current blink phase.
  function automatic logic [1:0] mode_outputs(input mode_t m, input logic blink_phase);
    logic [1:0] pair;
    case (m)
      MODE_OFF:     pair = 2'b10;
      MODE_RECT:    pair = 2'b11;
      MODE_OVERLAY: pair = 2'b01;
      MODE_BLINK:   pair = {1'b1, blink_phase};
      default:      pair = 2'b10;
    endcase
    return pair;
  endfunction

endpackage

// File: rtl/frame_boundary_detect.sv
// Frame-end strobe: high for the single cycle where the pixel counters sit
// on the last pixel of the last line. Exact compares only, so counter values
// outside the frame never produce a strobe.
module frame_boundary_detect
  import object_ctrl_pkg::*;
#(
  parameter int H_LAST = DEFAULT_H_LAST,
  parameter int V_LAST = DEFAULT_V_LAST
) (
  input  logic [9:0] HCount,
  input  logic [9:0] VCount,
  output logic       frame_end
);

  assign frame_end = (HCount == 10'(H_LAST)) && (VCount == 10'(V_LAST));

endmodule

// File: rtl/object_mode_scheduler.sv
// Frame-synchronous mode sequencer for the rectangle object. Mode-advance
// requests are collected during a frame and committed only on the frame-end
// edge, together with a one-cycle frame_tick, so the renderer never sees a
// mid-frame mode change. All outputs are registered.
// Optional feature: define RECT_BLINK_EN to add the BLINK mode and its
// frame-counting blink engine (OFF->RECT->OVERLAY->BLINK->OFF).
module object_mode_scheduler
  import object_ctrl_pkg::*;
#(
  parameter int H_LAST       = DEFAULT_H_LAST,
  parameter int V_LAST       = DEFAULT_V_LAST,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] HCount,
  input  logic [9:0] VCount,
  input  logic       mode_req,
  input  logic       hold,
  output logic       rectangle_select,
  output logic       full_screen,
  output logic       frame_tick,
  output logic [1:0] mode
);

  logic  frame_end;
  mode_t mode_reg, mode_next;
  logic  pending_reg, pending_next;
  logic  rect_sel_reg, full_screen_reg, frame_tick_reg;
  logic  phase_next;
  logic [1:0] out_pair_next;

  frame_boundary_detect #(
    .H_LAST(H_LAST),
    .V_LAST(V_LAST)
  ) u_frame_boundary_detect (
    .HCount   (HCount),
    .VCount   (VCount),
    .frame_end(frame_end)
  );

  function automatic mode_t advance_mode(input mode_t m);
    mode_t n;
    case (m)
      MODE_OFF:     n = MODE_RECT;
      MODE_RECT:    n = MODE_OVERLAY;
`ifdef RECT_BLINK_EN
      MODE_OVERLAY: n = MODE_BLINK;
`else
      MODE_OVERLAY: n = MODE_OFF;
`endif
      default:      n = MODE_OFF;
    endcase
    return n;
  endfunction

  // Mode FSM next state: a request arriving on the frame-end cycle itself
  // still counts for that frame end; hold defers the commit but keeps it pending.
  always_comb begin
    mode_next    = mode_reg;
    pending_next = pending_reg;
    if (mode_req) begin
      pending_next = 1'b1;
    end
    if (frame_end && (pending_reg || mode_req) && !hold) begin
      mode_next    = advance_mode(mode_reg);
      pending_next = 1'b0;
    end
  end

`ifdef RECT_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [7:0] count_reg, count_next;
  logic       phase_reg;

  // Blink engine: counts frames while in BLINK (hold does not pause it),
  // restarts visible on entry and clears itself once BLINK is left.
  always_comb begin
    count_next = count_reg;
    phase_next = phase_reg;
    if (frame_end) begin
      if (mode_next != MODE_BLINK) begin
        count_next = 8'd0;
        phase_next = 1'b0;
      end else if (mode_reg != MODE_BLINK) begin
        count_next = 8'd0;
        phase_next = 1'b1;
      end else if (count_reg == BLINK_LAST) begin
        count_next = 8'd0;
        phase_next = ~phase_reg;
      end else begin
        count_next = count_reg + 8'd1;
      end
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= 8'd0;
      phase_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      phase_reg <= phase_next;
    end
  end
`else
  // Without BLINK the phase is never used; the blink period is left unconnected.
  logic [7:0] blink_frames_unused;
  assign blink_frames_unused = 8'(BLINK_FRAMES);
  assign phase_next          = 1'b0;
`endif

  assign out_pair_next = mode_outputs(mode_next, phase_next);

  // State and output registers; mode-dependent outputs update on the same
  // edge as frame_tick because they are derived from the next mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg        <= MODE_OFF;
      pending_reg     <= 1'b0;
      full_screen_reg <= 1'b1;
      rect_sel_reg    <= 1'b0;
      frame_tick_reg  <= 1'b0;
    end else begin
      mode_reg        <= mode_next;
      pending_reg     <= pending_next;
      full_screen_reg <= out_pair_next[1];
      rect_sel_reg    <= out_pair_next[0];
      frame_tick_reg  <= frame_end;
    end
  end

  assign mode             = mode_reg;
  assign full_screen      = full_screen_reg;
  assign rectangle_select = rect_sel_reg;
  assign frame_tick       = frame_tick_reg;

endmodule
